// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - round-robin arbiter funnelling N cache-bus burst requesters onto one memory bus
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   resetn        asynchronous active-low reset
//   ireqs[i]      burst request from requester i (0 = icache, 1 = dcache)
//   iresps[i]     response routed back to requester i (zero unless it is the grantee)
//   oreq          request forwarded to the memory-side bus (zero while idle)
//   oresp         response from the memory-side bus
//   busy          a granted burst is in flight
//   grant_idx     current or most recent grantee
//   protocol_err  sticky: a burst's response beat count disagreed with its len

package cbus_pkg;
    // len encodes beats minus one
    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN4  = 8'd3;
    localparam logic [7:0] MLEN8  = 8'd7;
    localparam logic [7:0] MLEN16 = 8'd15;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             protocol_err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [7:0]       r_beat_cnt;
    logic [7:0]       r_len;
    logic             r_perr;

    logic             w_any_valid;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_cand;
    logic             w_start;
    logic             w_beat;
    logic             w_done;

    // Round-robin search: walk from the farthest candidate back to
    // last_grant+1 so the nearest valid requester is the final assignment.
    always_comb begin
        w_any_valid = 1'b0;
        w_pick      = '0;
        w_cand      = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            w_cand = IDX_W'((int'(r_last_grant) + k) % NUM_INPUTS);
            if (ireqs[w_cand].valid) begin
                w_any_valid = 1'b1;
                w_pick      = w_cand;
            end
        end
    end

    assign w_start = (r_state == S_IDLE) && w_any_valid;
    assign w_beat  = (r_state == S_BUSY) && oresp.ready;
    assign w_done  = w_beat && oresp.last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion goes straight to IDLE without granting, which guarantees
    // at least one idle cycle between bursts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done)      w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_INPUTS - 1);
            r_beat_cnt   <= 8'd0;
            r_len        <= 8'd0;
            r_perr       <= 1'b0;
        end else begin
            if (w_start) begin
                r_grant    <= w_pick;
                r_len      <= ireqs[w_pick].len;
                r_beat_cnt <= 8'd0;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (oresp.last) begin
                    r_last_grant <= r_grant;
                    if (r_beat_cnt != r_len) begin
                        r_perr <= 1'b1;
                    end
                end else if (r_beat_cnt == r_len) begin
                    // beat beyond the declared length; keep waiting for last
                    r_perr <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        oreq = '0;
        if (r_state == S_BUSY) begin
            oreq = ireqs[r_grant];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
            if ((r_state == S_BUSY) && (r_grant == IDX_W'(i))) begin
                iresps[i] = oresp;
            end
        end
    end

    assign busy         = (r_state == S_BUSY);
    assign grant_idx    = r_grant;
    assign protocol_err = r_perr;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - self-checking bench for cbus_arbiter
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N = 3;

    logic       clk;
    logic       resetn;
    cbus_req_t  reqs  [N];
    cbus_resp_t resps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [1:0] grant_idx;
    logic       perr;

    int checks;
    int errors;
    int m_last;
    bit m_perr;

    logic [7:0] len_tab [4];

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk(clk),
        .resetn(resetn),
        .ireqs(reqs),
        .iresps(resps),
        .oreq(oreq),
        .oresp(oresp),
        .busy(busy),
        .grant_idx(grant_idx),
        .protocol_err(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round robin from the rules: first valid requester after the last grantee.
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (reqs[(m_last + k) % N].valid) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic mk_req(input int i, input bit wr, input logic [7:0] len);
        reqs[i].valid  = 1'b1;
        reqs[i].write  = wr;
        reqs[i].addr   = $urandom;
        reqs[i].len    = len;
        reqs[i].data   = {$urandom, $urandom};
        reqs[i].strobe = wr ? 8'($urandom) : 8'h00;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) reqs[i] = '0;
    endtask

    task automatic chk_idle();
        chk("idle_busy", 128'(busy), 128'(1'b0));
        chk("idle_oreq", 128'(oreq), 128'(0));
        for (int i = 0; i < N; i++) chk($sformatf("idle_iresp%0d", i), 128'(resps[i]), 128'(0));
        chk("perr", 128'(perr), 128'(m_perr));
    endtask

    task automatic chk_routing(input int w);
        chk("busy", 128'(busy), 128'(1'b1));
        chk("grant", 128'(grant_idx), 128'(w));
        chk("oreq_fwd", 128'(oreq), 128'(reqs[w]));
        for (int i = 0; i < N; i++) begin
            if (i == w) chk($sformatf("iresp%0d_fwd", i), 128'(resps[i]), 128'(oresp));
            else        chk($sformatf("iresp%0d_zero", i), 128'(resps[i]), 128'(0));
        end
    endtask

    // Runs one whole burst starting from IDLE (time = just after a rising edge).
    // extra: beats sent beyond (or short of) len+1; late: valids raised on the last beat.
    task automatic run_txn(input int extra, input bit pattern, input bit drop_mid, input logic [N-1:0] late);
        int w;
        int beats;
        logic [7:0] lenv;
        logic [7:0] bv;
        w = pick();
        if (w < 0) begin
            chk("no_requester", 128'(0), 128'(1));
            return;
        end
        oresp = {1'($urandom), 1'($urandom), $urandom, $urandom};
        @(negedge clk);
        chk_idle();
        @(posedge clk); #1;
        lenv  = reqs[w].len;
        beats = int'(lenv) + 1 + extra;
        for (int b = 0; b < beats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                oresp = {1'b0, 1'($urandom), $urandom, $urandom};
                @(negedge clk);
                chk_routing(w);
                @(posedge clk); #1;
            end
            oresp = {1'b1, (b == beats - 1), $urandom, $urandom};
            if (pattern) begin
                bv = 8'((b + 1) * 17);
                reqs[w].data = {8{bv}};
            end
            if (drop_mid && b == 1) reqs[w].valid = 1'b0;
            if (b == beats - 1) begin
                for (int i = 0; i < N; i++) if (late[i]) reqs[i].valid = 1'b1;
            end
            @(negedge clk);
            chk_routing(w);
            @(posedge clk); #1;
        end
        m_last = w;
        if (beats != int'(lenv) + 1) m_perr = 1'b1;
        oresp = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        len_tab[0] = MLEN1;
        len_tab[1] = MLEN4;
        len_tab[2] = MLEN8;
        len_tab[3] = MLEN16;
        clear_reqs();
        oresp  = '0;
        resetn = 1'b0;
        m_last = N - 1;
        m_perr = 1'b0;

        // reset state, with requests and responses active during reset
        repeat (2) @(posedge clk);
        #1;
        oresp = {1'b1, 1'b1, $urandom, $urandom};
        mk_req(1, 0, MLEN4);
        @(negedge clk);
        chk("rst_grant", 128'(grant_idx), 128'(0));
        chk_idle();
        @(posedge clk); #1;
        clear_reqs();
        oresp  = '0;
        resetn = 1'b1;

        // single 16-beat read from requester 1
        mk_req(1, 0, MLEN16);
        reqs[1].addr = 32'h8000_1000;
        run_txn(0, 0, 0, '0);
        chk("read_grant_held", 128'(grant_idx), 128'(1));
        clear_reqs();

        // contention between requesters 0 and 1 alternates
        mk_req(0, 0, MLEN4);
        mk_req(1, 0, MLEN4);
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 0, 0, '0);
            chk("contention_order", 128'(grant_idx), 128'(k % 2));
        end
        clear_reqs();

        // write with per-beat data pattern and full strobe
        mk_req(0, 1, MLEN4);
        reqs[0].strobe = 8'hFF;
        run_txn(0, 1, 0, '0);
        clear_reqs();

        // requester 1 raises valid on requester 0's last beat
        mk_req(1, 0, MLEN4);
        reqs[1].valid = 1'b0;
        mk_req(0, 0, MLEN4);
        run_txn(0, 0, 0, 3'b010);
        reqs[0].valid = 1'b0;
        run_txn(0, 0, 0, '0);
        chk("late_grant", 128'(grant_idx), 128'(1));
        clear_reqs();

        // a valid pulse between edges is never granted
        mk_req(2, 0, MLEN4);
        #2;
        reqs[2].valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("glitch_no_grant", 128'(busy), 128'(1'b0));
        @(posedge clk); #1;

        // grantee drops valid mid-burst; only last ends the burst
        mk_req(2, 0, MLEN8);
        run_txn(0, 0, 1, '0);
        clear_reqs();

        // randomized well-formed bursts
        for (int it = 0; it < 12; it++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                mk_req(i, 1'($urandom), len_tab[$urandom_range(0, 3)]);
                reqs[i].valid = mask[i];
            end
            run_txn(0, 1'($urandom), 0, '0);
        end
        clear_reqs();

        // early last sets the sticky error, which survives a correct burst
        mk_req(1, 0, MLEN8);
        run_txn(-3, 0, 0, '0);
        clear_reqs();
        mk_req(0, 0, MLEN4);
        run_txn(0, 0, 0, '0);
        clear_reqs();
        @(negedge clk);
        chk("perr_sticky", 128'(perr), 128'(1'b1));
        @(posedge clk); #1;

        // reset in the middle of a 16-beat burst
        mk_req(0, 0, MLEN16);
        mk_req(1, 0, MLEN16);
        @(negedge clk);
        chk_idle();
        @(posedge clk); #1;
        begin
            int w;
            w = pick();
            @(negedge clk);
            chk_routing(w);
        end
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            oresp = {1'b1, 1'b0, $urandom, $urandom};
        end
        @(posedge clk); #1;
        oresp  = {1'b1, 1'b1, $urandom, $urandom};
        resetn = 1'b0;
        m_last = N - 1;
        m_perr = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(oreq.valid), 128'(1'b0));
        chk("rst_mid_grant", 128'(grant_idx), 128'(0));
        chk_idle();
        @(posedge clk); #1;
        oresp  = '0;
        resetn = 1'b1;
        run_txn(0, 0, 0, '0);
        chk("rst_regrant", 128'(grant_idx), 128'(0));
        clear_reqs();

        // randomized bursts including short, long and abandoned-valid ones
        for (int it = 0; it < 12; it++) begin
            logic [N-1:0] mask;
            int extra;
            int w;
            bit drop;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                mk_req(i, 1'($urandom), len_tab[$urandom_range(0, 3)]);
                reqs[i].valid = mask[i];
            end
            w = pick();
            extra = 0;
            case ($urandom_range(0, 4))
                0: extra = (reqs[w].len > 0) ? -1 : 1;
                1: extra = 2;
                default: extra = 0;
            endcase
            drop = (reqs[w].len > 0) && ($urandom_range(0, 3) == 0);
            run_txn(extra, 1'($urandom), drop, '0);
        end
        clear_reqs();
        @(negedge clk);
        chk_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 2, meaning the number of cache-bus requesters (legal range 2..4).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port ireqs  input  NUM_INPUTS x cbus_req_t  per-requester burst requests (index 0 = icache, 1 = dcache by convention).
REQ-005 The block SHALL have port iresps  output  NUM_INPUTS x cbus_resp_t  per-requester responses.
REQ-006 The block SHALL have port oreq  output  cbus_req_t  request to the single memory-side cache bus.
REQ-007 The block SHALL have port oresp  input  cbus_resp_t  response from the memory-side cache bus.
REQ-008 The block SHALL have port busy  output  1  high while a granted transaction is in flight.
REQ-009 The block SHALL have port grant_idx  output  clog2(NUM_INPUTS)  index of the current or most recent grantee.
REQ-010 The block SHALL have port protocol_err  output  1  sticky flag: response beat count disagreed with the granted request's len.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE, BUSY.
REQ-012 In IDLE, if any ireqs[i].valid is high, the block SHALL register a grant on the next clock edge and enter BUSY; the arbitration latency is exactly 1 cycle, and oreq.valid SHALL be 0 in IDLE.
REQ-013 Grant selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_INPUTS; the first valid requester wins.
REQ-014 In BUSY, oreq SHALL equal ireqs[grant_idx] combinationally, all fields including valid and per-beat data/strobe.
REQ-015 In BUSY, iresps[grant_idx] SHALL equal oresp; all other iresps SHALL be all-zero.
REQ-016 In IDLE, all iresps SHALL be all-zero, whatever oresp carries.
REQ-017 In BUSY, a beat counter (8 bits, cleared on grant) SHALL increment on each oresp.ready.
REQ-018 On oresp.ready && oresp.last, the block SHALL return to IDLE on that edge, and last_grant SHALL become grant_idx.
REQ-019 At that completing beat, if beat counter != latched ireqs[grant_idx].len (len latched at grant), protocol_err SHALL set and stay set until reset.
REQ-020 oresp.ready without last when the counter already equals len SHALL also set protocol_err; the FSM SHALL still wait for last.
REQ-021 A grantee dropping valid mid-burst SHALL NOT end BUSY; only last ends it, and oreq.valid follows the requester's valid.
REQ-022 A requester that becomes valid in the same cycle a transaction completes SHALL NOT be granted until the following IDLE cycle (minimum one IDLE cycle between bursts).
REQ-023 A request in IDLE whose valid deasserts before the grant edge is not granted; valid is sampled only at the IDLE edge.
REQ-024 busy SHALL be 1 exactly when state is BUSY.
REQ-025 Requesters SHALL hold valid and address/len stable until they see last; the block neither queues nor reorders requests.

Reset
REQ-026 When resetn is low, the block SHALL immediately force: state IDLE, oreq all-zero, iresps all-zero, busy 0, grant_idx 0, beat counter 0, protocol_err 0, and last_grant NUM_INPUTS-1 so that requester 0 wins first.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no completion beat forwarded; after release, arbitration restarts from REQ-026 state.

Verification
REQ-028 Single read: ireqs[1] valid, read, len=MLEN16, addr 0x80001000 -> one cycle later oreq.addr=0x80001000 and busy=1; 16 ready beats, last on 16th -> iresps[1] sees 16 beats, iresps[0] all-zero, IDLE next cycle, protocol_err=0.
REQ-029 Contention: both valid from reset, len=MLEN4 each -> grant 0 first, then grant 1 after one IDLE cycle; repeated contention alternates 0,1,0,1.
REQ-030 Write forwarding: requester 0 write, len=MLEN4, data changes each beat (0x11..,0x22..,0x33..,0x44..) -> oreq.data matches each beat in the same cycle; strobe 0xFF passed through.
REQ-031 Protocol error: len=MLEN8 granted, memory asserts last on beat 5 -> protocol_err=1 and stays 1 through later correct bursts; FSM returns to IDLE.
REQ-032 Reset mid-burst: resetn low after beat 3 of a 16-beat burst -> same cycle oreq.valid=0, busy=0; after release, pending requester 0 is granted first.
REQ-033 Late-valid: requester 1 asserts valid on requester 0's last-beat cycle -> requester 1 is granted after one IDLE cycle, not on that edge.
